ig_stream: RTL



---
 rtl/ig_pkg.sv | 23 ++
 rtl/ig_line_buf.sv | 41 ++++
 rtl/ig_stream.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/ig_pkg.sv
// ig_pkg: shared types and helpers for the image-gradient stream engine.
//   state_t   : controller states
//   grad_w    : width of one signed gradient component for a given pixel width
//   pack_grad : packs {gx, gy} into one word, gx in the upper field
package ig_pkg;

    typedef enum logic [1:0] {IDLE, READ, FLUSH, DRAIN} state_t;

    // One extra bit holds the sign of a difference of two unsigned pixels.
    function automatic int unsigned grad_w(input int unsigned pix_w);
        return pix_w + 1;
    endfunction

    // Each field is masked to gw bits so the lower field cannot spill upward.
    function automatic logic [63:0] pack_grad(input logic [31:0] gx,
                                              input logic [31:0] gy,
                                              input int unsigned gw);
        logic [63:0] mask;
        mask = (64'(1) << gw) - 64'(1);
        return ((64'(gx) & mask) << gw) | (64'(gy) & mask);
    endfunction

endpackage

// File: rtl/ig_line_buf.sv
// ig_line_buf: DEPTH-entry circular delay line, one push per enabled cycle.
//   clk, reset : clock, asynchronous active-high reset (pointer only)
//   en         : push din this cycle
//   din        : pixel pushed
//   dout_c     : pixel pushed DEPTH enables earlier (read before the write)
module ig_line_buf
    import ig_pkg::*;
#(
    parameter int unsigned DEPTH = 256,
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout_c
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [PW-1:0]    ptr;
    logic [WIDTH-1:0] mem [DEPTH];

    // Wrap-around pointer; storage itself needs no reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr <= '0;
        end else if (en) begin
            ptr <= (ptr == PW'(DEPTH - 1)) ? '0 : ptr + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (en) begin
            mem[ptr] <= din;
        end
    end

    assign dout_c = mem[ptr];

endmodule

// File: rtl/ig_stream.sv
// ig_stream: streams an IMG_W x IMG_H frame from image RAM in raster order
// and writes forward-difference gradients {gx, gy} to gradient RAM.
// Optional macro IG_BORDER_EN: also write border pixels using replicated
// neighbours (adds a FLUSH phase); otherwise border writes are suppressed.
//   clk, reset : clock, asynchronous active-high reset
//   start      : frame request, sampled in IDLE (not in the done cycle)
//   busy, done : frame in progress / one-cycle completion pulse
//   img_rd, img_addr, img_di    : image read port, data one cycle after img_rd
//   grad_wr, grad_addr, grad_do : gradient write port, {gx, gy} signed fields
module ig_stream
    import ig_pkg::*;
#(
    parameter int unsigned IMG_W  = 256,
    parameter int unsigned IMG_H  = 256,
    parameter int unsigned PIX_W  = 8,
    parameter int unsigned ADDR_W = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    output logic                   busy,
    output logic                   done,
    output logic                   img_rd,
    output logic [ADDR_W-1:0]      img_addr,
    input  logic [PIX_W-1:0]       img_di,
    output logic                   grad_wr,
    output logic [ADDR_W-1:0]      grad_addr,
    output logic [2*(PIX_W+1)-1:0] grad_do
);

    localparam int unsigned GW = grad_w(PIX_W);
    localparam int unsigned DW = 2 * GW;
    localparam int unsigned N  = IMG_W * IMG_H;
    localparam int unsigned XW = $clog2(IMG_W);
    localparam int unsigned YW = $clog2(IMG_H);
    localparam int unsigned CW = $clog2(IMG_W + 2);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N - 1);

    state_t            state, state_n;
    logic [CW-1:0]     cnt, cnt_n;
    logic              busy_n, done_n, img_rd_n;
    logic [ADDR_W-1:0] img_addr_n;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    // Next-state logic; cnt times FLUSH (IMG_W+1 cycles) and DRAIN (2 cycles).
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        case (state)
            IDLE: begin
                if (start && !done) begin
                    state_n = READ;
                    cnt_n   = '0;
                end
            end
            READ: begin
                if (img_addr == LAST_ADDR) begin
`ifdef IG_BORDER_EN
                    state_n = FLUSH;
`else
                    state_n = DRAIN;
`endif
                    cnt_n = '0;
                end
            end
            FLUSH: begin
                if (cnt == CW'(IMG_W)) begin
                    state_n = DRAIN;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            DRAIN: begin
                if (cnt == CW'(1)) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Next values of the registered control outputs.
    always_comb begin
        busy_n     = (state_n != IDLE);
        done_n     = (state == DRAIN) && (state_n == IDLE);
        img_rd_n   = (state_n == READ);
        img_addr_n = img_addr;
        if (state == IDLE && state_n == READ) begin
            img_addr_n = '0;
        end else if (state == READ && state_n == READ) begin
            img_addr_n = img_addr + ADDR_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy     <= 1'b0;
            done     <= 1'b0;
            img_rd   <= 1'b0;
            img_addr <= '0;
        end else begin
            busy     <= busy_n;
            done     <= done_n;
            img_rd   <= img_rd_n;
            img_addr <= img_addr_n;
        end
    end

    // ---------------- gradient pipeline ----------------
    logic              rd_q;
    logic              pipe_en;
    logic [PIX_W-1:0]  pix_in, lb_out, cur_q, lb_q;
    logic [CW-1:0]     fill;
    logic [XW-1:0]     xj;
    logic [YW-1:0]     yj;
    logic [ADDR_W-1:0] jaddr;
    logic [GW-1:0]     gx, gy, gx_e, gy_e;
    logic              last_col, last_row, wr_ok, emit;

`ifdef IG_BORDER_EN
    logic flush_q;
    // During FLUSH the last real pixel is recirculated; its value only feeds
    // components that are forced to zero below.
    assign pipe_en = rd_q | flush_q;
    assign pix_in  = flush_q ? cur_q : img_di;
`else
    assign pipe_en = rd_q;
    assign pix_in  = img_di;
`endif

    ig_line_buf #(
        .DEPTH (IMG_W),
        .WIDTH (PIX_W)
    ) u_line_buf (
        .clk    (clk),
        .reset  (reset),
        .en     (pipe_en),
        .din    (pix_in),
        .dout_c (lb_out)
    );

    // With pixel k entering: lb_out = p(j+1), lb_q = p(j), cur_q = p(j+IMG_W),
    // where j = k - (IMG_W+1).
    assign gx       = GW'(lb_out) - GW'(lb_q);
    assign gy       = GW'(cur_q) - GW'(lb_q);
    assign last_col = (xj == XW'(IMG_W - 1));
    assign last_row = (yj == YW'(IMG_H - 1));
    assign emit     = pipe_en && (fill == CW'(IMG_W + 1));

`ifdef IG_BORDER_EN
    assign gx_e  = last_col ? '0 : gx;
    assign gy_e  = last_row ? '0 : gy;
    assign wr_ok = 1'b1;
`else
    assign gx_e  = gx;
    assign gy_e  = gy;
    assign wr_ok = !last_col && !last_row;
`endif

    // Pipeline registers, output-coordinate tracking and the gradient write.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_q      <= 1'b0;
`ifdef IG_BORDER_EN
            flush_q   <= 1'b0;
`endif
            cur_q     <= '0;
            lb_q      <= '0;
            fill      <= '0;
            xj        <= '0;
            yj        <= '0;
            jaddr     <= '0;
            grad_wr   <= 1'b0;
            grad_addr <= '0;
            grad_do   <= '0;
        end else begin
            rd_q    <= img_rd;
`ifdef IG_BORDER_EN
            flush_q <= (state == FLUSH);
`endif
            grad_wr <= 1'b0;
            if (state == IDLE) begin
                fill  <= '0;
                xj    <= '0;
                yj    <= '0;
                jaddr <= '0;
            end else if (pipe_en) begin
                cur_q <= pix_in;
                lb_q  <= lb_out;
                if (!emit) begin
                    fill <= fill + CW'(1);
                end else begin
                    if (wr_ok) begin
                        grad_wr   <= 1'b1;
                        grad_addr <= jaddr;
                        grad_do   <= DW'(pack_grad(32'(gx_e), 32'(gy_e), GW));
                    end
                    jaddr <= jaddr + ADDR_W'(1);
                    if (last_col) begin
                        xj <= '0;
                        yj <= yj + YW'(1);
                    end else begin
                        xj <= xj + XW'(1);
                    end
                end
            end
        end
    end

endmodule
